// File: rtl/bti_arb2_pkg.sv
// bti_arb2_pkg: BTI command, packet types and default widths shared by the arbiter and its neighbours
package bti_arb2_pkg;
  localparam int BTI_TIDW   = 4;
  localparam int BTI_ADDR_W = 32;
  localparam int BTI_DATA_W = 32;
  typedef enum logic [1:0] {
    BTI_CMD_RD = 2'd0,
    BTI_CMD_WR = 2'd1
  } bti_cmd_e;
  typedef struct packed {
    logic [BTI_TIDW-1:0]   tid;
    logic [BTI_ADDR_W-1:0] addr;
    bti_cmd_e              cmd;
    logic [BTI_DATA_W-1:0] data;
  } bti_req_pkt_t;
  typedef struct packed {
    logic [BTI_TIDW-1:0]   tid;
    logic [BTI_DATA_W-1:0] data;
    logic                  ok;
  } bti_rsp_pkt_t;
  // A held lock wins; otherwise a lone requester wins; a tie goes to rr.
  function automatic logic rr_pick(logic lock, logic lock_src, logic v0, logic v1, logic rr);
    return lock ? lock_src : (v0 & v1) ? rr : v1;
  endfunction
endpackage

// File: rtl/bti_arb2_if.sv
// bti_arb2_if: BTI request and response handshake bundles
interface bti_req_if_t;
  logic                       vld;
  logic                       rdy;
  bti_arb2_pkg::bti_req_pkt_t pkt;
  modport mst (output vld, output pkt, input rdy);
  modport slv (input vld, input pkt, output rdy);
endinterface

interface bti_rsp_if_t;
  logic                       vld;
  logic                       rdy;
  bti_arb2_pkg::bti_rsp_pkt_t pkt;
  modport mst (output vld, output pkt, input rdy);
  modport slv (input vld, input pkt, output rdy);
endinterface

// File: rtl/bti_arb2_sync_fifo.sv
// sync_fifo: single-clock FIFO; a push while full is dropped even if a pop lands in the same cycle
module sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;
  always_comb begin
    full_o  = cnt_q == (AW+1)'(DEPTH);
    empty_o = cnt_q == '0;
    do_push = push_i & !full_o;
    do_pop  = pop_i & !empty_o;
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    dout_o  = mem_q[rd_q];
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= (AW+1)'(DEPTH))
    else $error("sync_fifo: occupancy above depth");
endmodule

// File: rtl/bti_arb2.sv
// bti_arb2: merges two BTI masters onto one port with round-robin grant, stall lock
// and an outstanding-source FIFO that steers in-order responses back to their requester.
module bti_arb2
  import bti_arb2_pkg::*;
#(
  parameter int BTI_AW    = BTI_ADDR_W,
  parameter int BTI_DW    = BTI_DATA_W,
  parameter int OST_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  bti_req_if_t.slv bti_req_slv0,
  bti_rsp_if_t.mst bti_rsp_mst0,
  bti_req_if_t.slv bti_req_slv1,
  bti_rsp_if_t.mst bti_rsp_mst1,
  bti_req_if_t.mst bti_req_mst,
  bti_rsp_if_t.slv bti_rsp_slv
);
  localparam int OST_AW = $clog2(OST_DEPTH);
  logic grant, sel_vld, hs, pop, full, empty, head;
  logic rr_q, rr_d, lock_q, lock_d, lock_src_q, lock_src_d;
  assign grant            = rr_pick(lock_q, lock_src_q, bti_req_slv0.vld, bti_req_slv1.vld, rr_q);
  assign sel_vld          = grant ? bti_req_slv1.vld : bti_req_slv0.vld;
  assign bti_req_mst.vld  = rst_n & sel_vld & !full;
  assign bti_req_mst.pkt  = grant ? bti_req_slv1.pkt : bti_req_slv0.pkt;
  assign bti_req_slv0.rdy = rst_n & !grant & bti_req_mst.rdy & !full;
  assign bti_req_slv1.rdy = rst_n & grant & bti_req_mst.rdy & !full;
  assign hs               = bti_req_mst.vld & bti_req_mst.rdy;
  assign rr_d             = hs ? ~grant : rr_q;
  // A stalled presentation pins the grant so the packet cannot switch source.
  assign lock_d           = bti_req_mst.vld & !bti_req_mst.rdy;
  assign lock_src_d       = lock_d ? grant : lock_src_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q       <= 1'b0;
      lock_q     <= 1'b0;
      lock_src_q <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
    end
  end
  sync_fifo #(.DW(1), .DEPTH(OST_DEPTH)) u_src_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (hs),
    .pop_i   (pop),
    .din_i   (grant),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );
  assign bti_rsp_mst0.vld = rst_n & bti_rsp_slv.vld & !empty & !head;
  assign bti_rsp_mst1.vld = rst_n & bti_rsp_slv.vld & !empty & head;
  assign bti_rsp_mst0.pkt = bti_rsp_slv.pkt;
  assign bti_rsp_mst1.pkt = bti_rsp_slv.pkt;
  assign bti_rsp_slv.rdy  = rst_n & !empty & (head ? bti_rsp_mst1.rdy : bti_rsp_mst0.rdy);
  assign pop              = bti_rsp_slv.vld & bti_rsp_slv.rdy;
  assert property (@(posedge clk) disable iff (!rst_n)
    bti_req_mst.vld && !bti_req_mst.rdy |=> $stable(bti_req_mst.pkt))
    else $error("bti_arb2: request packet changed while stalled");
  assert property (@(posedge clk) disable iff (!rst_n) bti_rsp_slv.vld |-> !empty)
    else $error("bti_arb2: response arrived with nothing outstanding");
  assert property (@(posedge clk) OST_DEPTH >= 2 && OST_DEPTH == (1 << OST_AW)
    && $bits(bti_req_mst.pkt.addr) == BTI_AW && $bits(bti_req_mst.pkt.data) == BTI_DW)
    else $error("bti_arb2: bad depth or width parameters");
endmodule

// File: tb/tb_bti_arb2.sv
// tb_bti_arb2: directed scoreboard bench; a small downstream model answers every granted request
module tb_bti_arb2;
  import bti_arb2_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  bti_req_if_t req0 ();
  bti_req_if_t req1 ();
  bti_req_if_t reqm ();
  bti_rsp_if_t rsp0 ();
  bti_rsp_if_t rsp1 ();
  bti_rsp_if_t rspm ();
  bti_arb2 #(.OST_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bti_req_slv0 (req0),
    .bti_rsp_mst0 (rsp0),
    .bti_req_slv1 (req1),
    .bti_rsp_mst1 (rsp1),
    .bti_req_mst  (reqm),
    .bti_rsp_slv  (rspm)
  );
  int total = 0;
  int bad = 0;
  bti_req_pkt_t srcq[2][$];
  bti_req_pkt_t exp_req[$];
  bti_rsp_pkt_t exp_rsp[2][$];
  bti_rsp_pkt_t dsq[$];
  logic en0, en1, ds_rdy, ds_rsp_en, prdy0, prdy1;
  int n_grant, n_rsp0, n_rsp1;
  logic rdy1_seen, o_mvld, o_s0rdy, o_s1rdy, o_rsprdy, o_r0vld, o_r1vld;
  bti_req_pkt_t o_mpkt;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bti_req_pkt_t mk(int p, int i);
    bti_req_pkt_t r;
    r.tid  = BTI_TIDW'((p << 3) | (i & 7));
    r.addr = (32'(p) << 28) | (32'(i) << 2);
    r.cmd  = (i % 2) != 0 ? BTI_CMD_WR : BTI_CMD_RD;
    r.data = 32'hD000_0000 | (32'(p) << 16) | 32'(i);
    return r;
  endfunction

  function automatic bti_rsp_pkt_t rsp_of(bti_req_pkt_t r);
    bti_rsp_pkt_t s;
    s.tid  = r.tid;
    s.data = r.addr ^ r.data;
    s.ok   = r.cmd == BTI_CMD_RD;
    return s;
  endfunction

  task automatic send(int p, int i);
    srcq[p].push_back(mk(p, i));
    exp_rsp[p].push_back(rsp_of(mk(p, i)));
  endtask

  task automatic expect_grant(int p, int i);
    exp_req.push_back(mk(p, i));
  endtask

  task automatic drive();
    req0.vld = en0 && srcq[0].size() > 0;
    if (srcq[0].size() > 0) req0.pkt = srcq[0][0]; else req0.pkt = '0;
    req1.vld = en1 && srcq[1].size() > 0;
    if (srcq[1].size() > 0) req1.pkt = srcq[1][0]; else req1.pkt = '0;
    reqm.rdy = ds_rdy;
    rspm.vld = ds_rsp_en && dsq.size() > 0;
    if (dsq.size() > 0) rspm.pkt = dsq[0]; else rspm.pkt = '0;
    rsp0.rdy = prdy0;
    rsp1.rdy = prdy1;
  endtask

  task automatic observe();
    o_mvld = reqm.vld;
    o_mpkt = reqm.pkt;
    o_s0rdy = req0.rdy;
    o_s1rdy = req1.rdy;
    o_rsprdy = rspm.rdy;
    o_r0vld = rsp0.vld;
    o_r1vld = rsp1.vld;
    rdy1_seen = rdy1_seen | req1.rdy;
    if (reqm.vld && reqm.rdy) begin
      n_grant++;
      if (exp_req.size() == 0) chk("grant_unexpected", 128'(exp_req.size()), 128'(1));
      else chk("grant_pkt", 128'(reqm.pkt), 128'(exp_req.pop_front()));
      dsq.push_back(rsp_of(reqm.pkt));
    end
    if (req0.vld && req0.rdy) void'(srcq[0].pop_front());
    if (req1.vld && req1.rdy) void'(srcq[1].pop_front());
    if (rspm.vld && rspm.rdy) void'(dsq.pop_front());
    if (rsp0.vld && rsp0.rdy) begin
      n_rsp0++;
      if (exp_rsp[0].size() == 0) chk("rsp0_unexpected", 128'(exp_rsp[0].size()), 128'(1));
      else chk("rsp0_pkt", 128'(rsp0.pkt), 128'(exp_rsp[0].pop_front()));
    end
    if (rsp1.vld && rsp1.rdy) begin
      n_rsp1++;
      if (exp_rsp[1].size() == 0) chk("rsp1_unexpected", 128'(exp_rsp[1].size()), 128'(1));
      else chk("rsp1_pkt", 128'(rsp1.pkt), 128'(exp_rsp[1].pop_front()));
    end
  endtask

  task automatic tick();
    drive();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    en0 = 1'b1; en1 = 1'b0; ds_rdy = 1'b1; ds_rsp_en = 1'b1; prdy0 = 1'b1; prdy1 = 1'b1;
    n_grant = 0; n_rsp0 = 0; n_rsp1 = 0; rdy1_seen = 1'b0;
    // Reset with port 0 traffic already pending: nothing may handshake.
    for (int i = 0; i < 8; i++) begin
      send(0, i);
      expect_grant(0, i);
    end
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_mst_vld", 128'(o_mvld), 128'(0));
    chk("rst_slv0_rdy", 128'(o_s0rdy), 128'(0));
    chk("rst_rsp_rdy", 128'(o_rsprdy), 128'(0));
    chk("rst_rsp0_vld", 128'(o_r0vld), 128'(0));
    rst_n = 1'b1;
    // Port 0 alone, back to back.
    repeat (8) tick();
    chk("t1_grants_8cyc", 128'(n_grant), 128'(8));
    chk("t1_p1_rdy_never", 128'(rdy1_seen), 128'(0));
    repeat (2) tick();
    chk("t1_rsp0_cnt", 128'(n_rsp0), 128'(8));
    chk("t1_rsp1_cnt", 128'(n_rsp1), 128'(0));
    // Both ports continuously after reset: 0,1,0,1...
    do_reset();
    en1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(0, 10 + i);
      send(1, i);
      expect_grant(0, 10 + i);
      expect_grant(1, i);
    end
    n_grant = 0;
    repeat (8) tick();
    chk("t2_grants", 128'(n_grant), 128'(8));
    repeat (2) tick();
    chk("t2_left", 128'(exp_rsp[0].size() + exp_rsp[1].size() + exp_req.size()), 128'(0));
    // Make rr point at port 1, then stall port 0 and raise port 1 behind it.
    en1 = 1'b0;
    send(0, 20);
    expect_grant(0, 20);
    tick();
    ds_rdy = 1'b0;
    send(0, 21);
    send(1, 21);
    expect_grant(0, 21);
    expect_grant(1, 21);
    tick();
    chk("t3_pkt_first", 128'(o_mpkt), 128'(mk(0, 21)));
    en1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_pkt_stable", 128'(o_mpkt), 128'(mk(0, 21)));
      chk("t3_p1_rdy", 128'(o_s1rdy), 128'(0));
    end
    ds_rdy = 1'b1;
    n_grant = 0;
    repeat (2) tick();
    chk("t3_grants", 128'(n_grant), 128'(2));
    repeat (2) tick();
    // Response side stalled: the FIFO fills at four.
    prdy0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(0, 30 + i);
      expect_grant(0, 30 + i);
    end
    n_grant = 0;
    repeat (6) tick();
    chk("t4_accepted", 128'(n_grant), 128'(4));
    chk("t4_vld_full", 128'(o_mvld), 128'(0));
    prdy0 = 1'b1;
    n_grant = 0;
    tick();
    chk("t4_no_push_on_pop", 128'(n_grant), 128'(0));
    chk("t4_vld_on_pop", 128'(o_mvld), 128'(0));
    tick();
    chk("t4_push_after_pop", 128'(n_grant), 128'(1));
    repeat (8) tick();
    chk("t4_left", 128'(exp_rsp[0].size() + exp_req.size()), 128'(0));
    // Sources 0,1,1,0 outstanding, port 1 refuses responses for 3 cycles.
    ds_rsp_en = 1'b0;
    n_grant = 0;
    send(0, 40);
    expect_grant(0, 40);
    tick();
    send(1, 40);
    send(1, 41);
    expect_grant(1, 40);
    expect_grant(1, 41);
    repeat (2) tick();
    send(0, 41);
    expect_grant(0, 41);
    tick();
    chk("t5_grants", 128'(n_grant), 128'(4));
    prdy1 = 1'b0;
    ds_rsp_en = 1'b1;
    n_rsp0 = 0;
    n_rsp1 = 0;
    tick();
    chk("t5_first_rsp0", 128'(n_rsp0), 128'(1));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_stall_rdy", 128'(o_rsprdy), 128'(0));
      chk("t5_rsp1_vld", 128'(o_r1vld), 128'(1));
    end
    prdy1 = 1'b1;
    repeat (4) tick();
    chk("t5_rsp1_cnt", 128'(n_rsp1), 128'(2));
    chk("t5_rsp0_cnt", 128'(n_rsp0), 128'(2));
    // Reset with three requests outstanding; downstream model is reset too.
    ds_rsp_en = 1'b0;
    n_grant = 0;
    for (int i = 0; i < 3; i++) begin
      send(0, 50 + i);
      expect_grant(0, 50 + i);
    end
    repeat (3) tick();
    chk("t6_outstanding", 128'(n_grant), 128'(3));
    rst_n = 1'b0;
    dsq.delete();
    exp_rsp[0].delete();
    tick();
    chk("t6_rst_mvld", 128'(o_mvld), 128'(0));
    rst_n = 1'b1;
    ds_rsp_en = 1'b1;
    tick();
    chk("t6_post_mvld", 128'(o_mvld), 128'(0));
    chk("t6_post_rsp0_vld", 128'(o_r0vld), 128'(0));
    chk("t6_post_rsp1_vld", 128'(o_r1vld), 128'(0));
    chk("t6_post_rsp_rdy", 128'(o_rsprdy), 128'(0));
    send(0, 53);
    send(1, 53);
    expect_grant(0, 53);
    expect_grant(1, 53);
    n_grant = 0;
    repeat (4) tick();
    chk("t6_rr_grants", 128'(n_grant), 128'(2));
    chk("end_left", 128'(exp_req.size() + exp_rsp[0].size() + exp_rsp[1].size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
